// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_pkg
//  Description : Shared types and constants for the time-shared add/sub
//                arbiter: FSM state encoding, datapath width, op encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package addsub_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/adder_16bit_b.sv
`default_nettype none
// ============================================================================
//  Module      : adder_16bit_b
//  Description : 16-bit add/sub unit. {C_out, SUM} is the 17-bit result of
//                the zero-extended operands, so for a subtract C_out is the
//                borrow (1 when A < B unsigned).
//  Ports       : A, B   - operands
//                SUB    - 1 = A-B, 0 = A+B
//                SUM    - 16-bit result (wraps mod 2^16)
//                C_out  - bit 16 of the 17-bit result
//  Revision    : 1.0  initial release
// ============================================================================
module adder_16bit_b (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        SUB,
  output logic [15:0] SUM,
  output logic        C_out
);

  logic [16:0] w_res;

  assign w_res = SUB ? ({1'b0, A} - {1'b0, B}) : ({1'b0, A} + {1'b0, B});
  assign SUM   = w_res[15:0];
  assign C_out = w_res[16];

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first active
//                request at or above the pointer, wrapping at NREQ.
//  Ports       : i_req   - request vector
//                i_ptr   - index with highest priority this cycle
//                o_grant - one-hot grant (all zero when no request)
//                o_id    - encoded index of the granted request
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_id
);

  logic [IDW:0] w_idx;
  logic         w_found;

  // One extra bit on the index keeps ptr+k from wrapping before the
  // explicit mod-NREQ correction, so non-power-of-two NREQ works too.
  always_comb begin
    o_grant = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, i_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NREQ)) begin
        w_idx = w_idx - (IDW+1)'(NREQ);
      end
      if (!w_found && i_req[w_idx[IDW-1:0]]) begin
        o_grant[w_idx[IDW-1:0]] = 1'b1;
        o_id                    = w_idx[IDW-1:0];
        w_found                 = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/addsub_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_share_arb
//  Description : Time-shares one 16-bit add/sub unit among NREQ requesters
//                with round-robin arbitration. One operation in flight:
//                IDLE (grant) -> EXEC (compute) -> RESP (hold until taken).
//  Ports       : clk, rst_n            - clock, async active-low reset
//                req_valid/req_ready   - per-requester handshake
//                req_a/req_b/req_sub   - per-requester operands, 16 bits/slice
//                rsp_valid/rsp_ready   - response handshake
//                rsp_id/rsp_sum        - issuing requester and result
//                rsp_cout/rsp_ovf      - bit 16 of result, signed overflow
//                busy                  - high whenever not IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module addsub_share_arb
  import addsub_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]    req_sub,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [15:0]        rsp_sum,
  output logic               rsp_cout,
  output logic               rsp_ovf,
  output logic               busy
);

  state_t            r_state, w_state_nxt;
  logic [IDW-1:0]    r_rr_ptr, r_id, w_gnt_id, w_ptr_nxt;
  logic [NREQ-1:0]   w_grant;
  logic [DATA_W-1:0] r_a, r_b, w_sel_a, w_sel_b, w_sum;
  logic              r_sub, w_sel_sub, w_cout, w_ovf, w_take;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_id    (w_gnt_id)
  );

  assign w_take    = (r_state == IDLE) && (|req_valid);
  assign req_ready = (r_state == IDLE) ? w_grant : '0;
  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign w_ptr_nxt = (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + IDW'(1);

  // Operand select driven by the one-hot grant.
  always_comb begin
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_sub = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a   = req_a[i*DATA_W +: DATA_W];
        w_sel_b   = req_b[i*DATA_W +: DATA_W];
        w_sel_sub = req_sub[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_take) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch and round-robin pointer, updated only on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_id     <= '0;
      r_rr_ptr <= '0;
    end else if (w_take) begin
      r_a      <= w_sel_a;
      r_b      <= w_sel_b;
      r_sub    <= w_sel_sub;
      r_id     <= w_gnt_id;
      r_rr_ptr <= w_ptr_nxt;
    end
  end

  adder_16bit_b u_adder (
    .A     (r_a),
    .B     (r_b),
    .SUB   (r_sub == OP_SUB),
    .SUM   (w_sum),
    .C_out (w_cout)
  );

  // Signed overflow: result sign differs from A when the effective operand
  // signs agree (same signs for add, opposite signs for subtract).
  always_comb begin
    if (r_sub == OP_ADD) begin
      w_ovf = (r_a[15] == r_b[15]) && (w_sum[15] != r_a[15]);
    end else begin
      w_ovf = (r_a[15] != r_b[15]) && (w_sum[15] != r_a[15]);
    end
  end

  // Response registers load only in EXEC, so they stay stable through RESP
  // and keep their last value in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
      rsp_id   <= '0;
    end else if (r_state == EXEC) begin
      rsp_sum  <= w_sum;
      rsp_cout <= w_cout;
      rsp_ovf  <= w_ovf;
      rsp_id   <= r_id;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addsub_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_share_arb
//  Description : Self-checking bench for addsub_share_arb. A reference model
//                (round-robin pick over a pointer, integer arithmetic for
//                the result flags, queue of outstanding responses) is
//                compared against the DUT on every falling edge; directed
//                sequences add literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_addsub_share_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic [NREQ-1:0]    req_sub;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [15:0]        rsp_sum;
  logic               rsp_cout;
  logic               rsp_ovf;
  logic               busy;

  addsub_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [IDW-1:0] id;
    logic [15:0]    sum;
    logic           cout;
    logic           ovf;
  } exp_t;

  exp_t q[$];
  int   m_ptr   = 0;
  int   acc_cyc = 0;

  function automatic exp_t model_op(input int id, input logic [15:0] a,
                                    input logic [15:0] b, input logic s);
    exp_t e;
    int   sa, sb, r;
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    e.id = IDW'(id);
    if (s) begin
      r      = sa - sb;
      e.sum  = a - b;
      e.cout = (a < b);
    end else begin
      r      = sa + sb;
      e.sum  = a + b;
      e.cout = ((32'(a) + 32'(b)) > 32'h0000_FFFF);
    end
    e.ovf = (r > 32767) || (r < -32768);
    return e;
  endfunction

  always @(negedge clk) begin : compare
    int g;
    g = -1;
    if (!rst_n) begin
      chk("reset_outs", 32'({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, busy}), 32'd0);
      q.delete();
      m_ptr = 0;
    end else if (q.size() == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
      chk("m_busy_idle", 32'(busy), 32'd0);
      chk("m_rsp_valid_idle", 32'(rsp_valid), 32'd0);
      chk("m_req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      if (g >= 0) begin
        q.push_back(model_op(g, req_a[16*g +: 16], req_b[16*g +: 16], req_sub[g]));
        m_ptr   = (g + 1) % NREQ;
        acc_cyc = cyc;
      end
    end else begin
      chk("m_req_ready_busy", 32'(req_ready), 32'd0);
      chk("m_busy", 32'(busy), 32'd1);
      chk("m_rsp_valid_timing", 32'(rsp_valid), 32'(cyc >= acc_cyc + 2));
      if (rsp_valid) begin
        chk("m_rsp_id", 32'(rsp_id), 32'(q[0].id));
        chk("m_rsp_sum", 32'(rsp_sum), 32'(q[0].sum));
        chk("m_rsp_cout", 32'(rsp_cout), 32'(q[0].cout));
        chk("m_rsp_ovf", 32'(rsp_ovf), 32'(q[0].ovf));
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic drive_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
    @(posedge clk);
    #1;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_sub[i]        = s;
    req_valid[i]      = 1'b1;
  endtask

  task automatic wait_ready(input int i, output int c);
    bit ok;
    ok = 1'b0;
    c  = -1;
    for (int t = 0; t < 30 && !ok; t++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        ok = 1'b1;
        c  = cyc;
      end
    end
    chk($sformatf("ready_seen_%0d", i), 32'(ok), 32'd1);
  endtask

  task automatic drop(input int i);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int id, input logic [15:0] sum,
                          input logic cout, input logic ovf, output int c);
    bit ok;
    ok = 1'b0;
    c  = -1;
    for (int t = 0; t < 30 && !ok; t++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        c  = cyc;
      end
    end
    chk({name, "_seen"}, 32'(ok), 32'd1);
    chk({name, "_id"}, 32'(rsp_id), 32'(id));
    chk({name, "_sum"}, 32'(rsp_sum), 32'(sum));
    chk({name, "_cout"}, 32'(rsp_cout), 32'(cout));
    chk({name, "_ovf"}, 32'(rsp_ovf), 32'(ovf));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int c0, c1, ng;
    int ids [5];
    int gcs [5];
    int rr_exp [5];
    logic [19:0] snap;
    rr_exp = '{0, 1, 2, 3, 0};

    rst_n     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single add, latency accept-edge to rsp_valid = 2 cycles
    drive_req(0, 16'h0003, 16'h0004, 1'b0);
    wait_ready(0, c0);
    drop(0);
    wait_rsp("add_basic", 0, 16'h0007, 1'b0, 1'b0, c1);
    chk("latency", 32'(c1 - c0), 32'd2);

    // Signed overflow, add and sub
    drive_req(1, 16'h7FFF, 16'h0001, 1'b0);
    wait_ready(1, c0); drop(1);
    wait_rsp("add_ovf", 1, 16'h8000, 1'b0, 1'b1, c1);
    drive_req(2, 16'h8000, 16'h0001, 1'b1);
    wait_ready(2, c0); drop(2);
    wait_rsp("sub_ovf", 2, 16'h7FFF, 1'b0, 1'b1, c1);

    // Borrow and carry
    drive_req(3, 16'h0001, 16'h0002, 1'b1);
    wait_ready(3, c0); drop(3);
    wait_rsp("sub_borrow", 3, 16'hFFFF, 1'b1, 1'b0, c1);
    drive_req(0, 16'hFFFF, 16'h0001, 1'b0);
    wait_ready(0, c0); drop(0);
    wait_rsp("add_carry", 0, 16'h0000, 1'b1, 1'b0, c1);

    // Reset to bring the pointer back to 0, then all four requesting
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[16*i +: 16] = 16'(16'h1111 * (i + 1));
      req_b[16*i +: 16] = 16'(16'h0101 * (i + 3));
      req_sub[i]        = i[0];
    end
    req_valid = '1;
    ng = 0;
    for (int t = 0; t < 40 && ng < 5; t++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        chk("rr_onehot", 32'($onehot(req_ready)), 32'd1);
        ids[ng] = 0;
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) ids[ng] = k;
        gcs[ng] = cyc;
        ng++;
      end
    end
    @(posedge clk); #1 req_valid = '0;
    chk("rr_grants", 32'(ng), 32'd5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_id_%0d", k), 32'(ids[k]), 32'(rr_exp[k]));
      if (k > 0) chk($sformatf("rr_gap_%0d", k), 32'(gcs[k] - gcs[k-1]), 32'd3);
    end
    repeat (4) @(posedge clk);

    // Backpressure: response held for 10 cycles while requester 1 waits
    #1 rsp_ready = 1'b0;
    drive_req(2, 16'h1234, 16'h0FFF, 1'b1);
    wait_ready(2, c0);
    @(posedge clk);
    #1;
    req_valid[2]  = 1'b0;
    req_a[31:16]  = 16'h8000;
    req_b[31:16]  = 16'h8000;
    req_sub[1]    = 1'b0;
    req_valid[1]  = 1'b1;
    wait_rsp("bp_first", 2, 16'h0235, 1'b0, 1'b0, c1);
    snap = {rsp_id, rsp_sum, rsp_cout, rsp_ovf};
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("bp_hold", 32'({rsp_id, rsp_sum, rsp_cout, rsp_ovf}), 32'(snap));
      chk("bp_state", 32'({rsp_valid, busy, req_ready}), 32'h30);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release", 32'({rsp_valid, busy, req_ready}), 32'h02);
    drop(1);
    wait_rsp("bp_next", 1, 16'h0000, 1'b1, 1'b1, c1);

    // Reset during EXEC discards the operation and rewinds the pointer
    drive_req(1, 16'h0010, 16'h0001, 1'b0);
    wait_ready(1, c0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    req_valid[1] = 1'b0;
    #1;
    chk("rst_mid_outs", 32'({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, busy}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    req_a[47:32] = 16'h0005; req_b[47:32] = 16'h0007; req_sub[2] = 1'b1;
    req_a[63:48] = 16'h4000; req_b[63:48] = 16'h4000; req_sub[3] = 1'b0;
    req_valid[2] = 1'b1;
    req_valid[3] = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", 32'(req_ready), 32'h4);
    drop(2);
    wait_rsp("post_rst_r2", 2, 16'hFFFE, 1'b1, 1'b0, c1);
    wait_ready(3, c0);
    drop(3);
    wait_rsp("post_rst_r3", 3, 16'h8000, 1'b0, 1'b1, c1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
